ifu_fetch_ctrl: RTL

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl_pkg.sv | 18 +
 rtl/ifu_npc_sel.sv | 23 ++
 rtl/ifu_fetch_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg: shared defines for the instruction fetch controller.
package ifu_fetch_ctrl_pkg;

    localparam logic [31:0] RST_PC_DEFAULT = 32'h8000_0000;
    localparam logic        BRANCH_ENABLE  = 1'b1;
    localparam logic        RST_ENABLE     = 1'b1;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam int          INST_BYTES     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HANDOFF,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/ifu_npc_sel.sv
// ifu_npc_sel: next fetch PC selection (live redirect, then pending redirect, then sequential).
module ifu_npc_sel
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] npc
);

    // A live redirect is newer than any pending one, so it takes priority.
    always_comb begin
        redirect = branch_en_i == BRANCH_ENABLE || pend_valid;
        npc      = branch_en_i == BRANCH_ENABLE ? dnpc_i :
                   pend_valid ? pend_pc : pc + ADDR_W'(INST_BYTES);
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: AXI-lite instruction fetch sequencer with EXU redirect and IDU handoff.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(RST_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    output logic              fetch_err_o
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc_r, pend_pc, npc;
    logic              pend_valid, redirect, branch, resp_ok;
    logic              pc_load, inst_load, pend_set, pend_clr, err_set;

    assign branch   = branch_en_i == BRANCH_ENABLE;
    assign resp_ok  = rresp_i == RESP_OKAY;
    assign araddr_o = pc_r;

    ifu_npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
        .pc          (pc_r),
        .branch_en_i (branch_en_i),
        .dnpc_i      (dnpc_i),
        .pend_valid  (pend_valid),
        .pend_pc     (pend_pc),
        .redirect    (redirect),
        .npc         (npc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        inst_valid_o = 1'b0;
        pc_load      = 1'b0;
        inst_load    = 1'b0;
        pend_set     = 1'b0;
        pend_clr     = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE: begin
                pc_load   = branch;
                state_nxt = ADDR;
            end
            ADDR: begin
                arvalid_o = 1'b1;
                pend_set  = branch;
                state_nxt = arready_i ? DATA : ADDR;
            end
            // A beat that returns while a redirect is pending or arriving is dropped.
            DATA: begin
                rready_o  = 1'b1;
                pend_set  = branch;
                pend_clr  = rvalid_i;
                err_set   = rvalid_i && !resp_ok;
                pc_load   = rvalid_i && resp_ok && redirect;
                inst_load = rvalid_i && resp_ok && !redirect;
                state_nxt = !rvalid_i ? DATA : !resp_ok ? HALT : redirect ? ADDR : HANDOFF;
            end
            HANDOFF: begin
                inst_valid_o = 1'b1;
                pc_load      = inst_ready_i || branch;
                state_nxt    = pc_load ? ADDR : HANDOFF;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            pc_r        <= RST_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            inst_o      <= '0;
            pc_o        <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            if (pc_load)
                pc_r <= npc;
            if (inst_load) begin
                inst_o <= rdata_i;
                pc_o   <= pc_r;
            end
            if (pend_set)
                pend_pc <= dnpc_i;
            pend_valid <= pend_clr ? 1'b0 : pend_set ? 1'b1 : pend_valid;
            if (err_set)
                fetch_err_o <= 1'b1;
        end
    end

endmodule
